// File: rtl/booth_mult_r4.sv
// Radix-4 Booth multiplier, N-bit signed/unsigned operands, exact 2N-bit product.
// Latency: accept edge, then N/2+1 CALC edges; done pulses in the following cycle.
// Backpressure: ready is high only in IDLE; valid while busy is dropped, not queued.
module booth_mult_r4 #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid,
  output logic           ready,
  input  logic           signed_mode,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] Mult,
  output logic           done
);

  // Two guard bits let unsigned operands be treated as positive signed values.
  localparam int W  = N + 2;
  localparam int CW = $clog2(W / 2 + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  m;
  logic [W:0]    m2;
  logic [W+1:0]  h;
  logic [W-1:0]  q;
  logic          q_1;
  logic [CW-1:0] count;

  logic [W-1:0]  a_ext;
  logic [W-1:0]  b_ext;
  logic [W+1:0]  term;
  logic [W+1:0]  sum;
  logic [W+1:0]  h_nxt;
  logic [W-1:0]  q_nxt;

  // Operand extension: sign or zero fill depending on the requested mode.
  always_comb begin
    a_ext = signed_mode ? {{2{A[N-1]}}, A} : {2'b00, A};
    b_ext = signed_mode ? {{2{B[N-1]}}, B} : {2'b00, B};
  end

  // Booth digit decode on {Q[1:0],Q_1}; the selected term is sign-extended to W+2 bits.
  always_comb begin
    term = '0;
    case ({q[1:0], q_1})
      3'b001, 3'b010: term = {{2{m[W-1]}}, m};
      3'b011:         term = {m2[W], m2};
      3'b100:         term = -{m2[W], m2};
      3'b101, 3'b110: term = -{{2{m[W-1]}}, m};
      default:        term = '0;
    endcase
  end

  // Add into the high half, then arithmetic-shift the whole accumulator right by two.
  always_comb begin
    sum   = h + term;
    h_nxt = {{2{sum[W+1]}}, sum[W+1:2]};
    q_nxt = {sum[1:0], q[W-1:2]};
  end

  // Control FSM with registered ready/done; Mult is loaded from the final shifted value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      Mult  <= '0;
      m     <= '0;
      m2    <= '0;
      h     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          if (valid) begin
            m     <= a_ext;
            m2    <= {a_ext, 1'b0};
            h     <= '0;
            q     <= b_ext;
            q_1   <= 1'b0;
            count <= CW'(W / 2);
            ready <= 1'b0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          h     <= h_nxt;
          q     <= q_nxt;
          q_1   <= q[1];
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            // Low 2N bits of {H,Q}: the top N-2 bits of the product live in H.
            Mult  <= {h_nxt[N-3:0], q_nxt};
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_r4.sv
// Bench for booth_mult_r4: N=8 and N=16 instances on a shared clock and reset.
// Directed vector table, back-to-back, mid-operation reset and a small random sweep.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_booth_mult_r4;

  logic        clk;
  logic        rst;

  logic        valid8, ready8, sm8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] mult8;

  logic        valid16, ready16, sm16, done16;
  logic [15:0] a16, b16;
  logic [31:0] mult16;

  int errs;
  int checks;
  int cyc;

  booth_mult_r4 #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .valid(valid8), .ready(ready8), .signed_mode(sm8),
    .A(a8), .B(b8), .Mult(mult8), .done(done8)
  );

  booth_mult_r4 #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .valid(valid16), .ready(ready16), .signed_mode(sm16),
    .A(a16), .B(b16), .Mult(mult16), .done(done16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    bit          sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec8_t;

  vec8_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One N=8 operation; operands/mode are scrambled after accept to prove they are latched.
  task automatic op8(input string nm, input bit sm, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input bit full);
    int w;
    int lat;
    w = 0;
    @(negedge clk);
    while (!ready8 && w < 20) begin
      @(negedge clk);
      w++;
    end
    sm8 = sm; a8 = a; b8 = b; valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid8 = 1'b0; a8 = ~a; b8 = ~b; sm8 = ~sm;
    if (full) chk({nm, " ready_low"}, 64'(ready8), 64'd0);
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " mult"}, 64'(mult8), 64'(exp));
    if (full) begin
      chk({nm, " latency"}, 64'(lat), 64'd6);
      @(negedge clk);
      chk({nm, " done_pulse"}, 64'(done8), 64'd0);
      chk({nm, " ready_back"}, 64'(ready8), 64'd1);
    end
  endtask

  task automatic op16(input string nm, input bit sm, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp, input bit full);
    int w;
    int lat;
    w = 0;
    @(negedge clk);
    while (!ready16 && w < 20) begin
      @(negedge clk);
      w++;
    end
    sm16 = sm; a16 = a; b16 = b; valid16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid16 = 1'b0; a16 = ~a; b16 = ~b; sm16 = ~sm;
    lat = 1;
    while (!done16 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " mult"}, 64'(mult16), 64'(exp));
    if (full) begin
      chk({nm, " latency"}, 64'(lat), 64'd10);
      @(negedge clk);
      chk({nm, " done_pulse"}, 64'(done16), 64'd0);
    end
  endtask

  initial begin
    int nd;
    int t[2];
    logic [15:0] mv[2];
    int hold_bad;
    int extra;
    int w;
    logic [7:0]  ra, rb;
    logic [15:0] ra16, rb16;
    bit rs;
    longint x, y;

    errs = 0; checks = 0; cyc = 0;
    rst = 1'b1;
    valid8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    valid16 = 0; sm16 = 0; a16 = 0; b16 = 0;

    vecs[0]  = '{"s80x80", 1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1]  = '{"s7Fx80", 1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[2]  = '{"uFFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[3]  = '{"s00xA5", 1'b1, 8'h00, 8'hA5, 16'h0000};
    vecs[4]  = '{"u00xA5", 1'b0, 8'h00, 8'hA5, 16'h0000};
    vecs[5]  = '{"s01xFF", 1'b1, 8'h01, 8'hFF, 16'hFFFF};
    vecs[6]  = '{"u01xFF", 1'b0, 8'h01, 8'hFF, 16'h00FF};
    vecs[7]  = '{"sFBx03", 1'b1, 8'hFB, 8'h03, 16'hFFF1};
    vecs[8]  = '{"u80x80", 1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[9]  = '{"sFFxFF", 1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[10] = '{"u7Fx7F", 1'b0, 8'h7F, 8'h7F, 16'h3F01};
    vecs[11] = '{"s80x7F", 1'b1, 8'h80, 8'h7F, 16'hC080};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 64'(ready8), 64'd1);
    chk("reset done", 64'(done8), 64'd0);
    chk("reset mult", 64'(mult8), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle ready16", 64'(ready16), 64'd1);
    chk("idle mult16", 64'(mult16), 64'd0);

    foreach (vecs[i]) op8(vecs[i].name, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);

    // Back-to-back: valid held high, new operands presented right after each accept.
    w = 0;
    while (!ready8 && w < 20) begin @(negedge clk); w++; end
    sm8 = 1'b1; a8 = 8'h03; b8 = 8'hFB; valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h0C; b8 = 8'h0C;
    nd = 0; hold_bad = 0; t[0] = 0; t[1] = 0; mv[0] = 0; mv[1] = 0;
    for (int i = 0; i < 30 && nd < 2; i++) begin
      if (done8) begin
        t[nd] = cyc; mv[nd] = mult8; nd++;
        if (nd == 2) valid8 = 1'b0;
      end else if (nd == 1 && mult8 !== 16'hFFF1) begin
        hold_bad++;
      end
      if (nd < 2) @(negedge clk);
    end
    valid8 = 1'b0;
    chk("b2b done_count", 64'(nd), 64'd2);
    chk("b2b first", 64'(mv[0]), 64'hFFF1);
    chk("b2b second", 64'(mv[1]), 64'h0090);
    chk("b2b spacing", 64'(t[1] - t[0]), 64'd7);
    chk("b2b hold", 64'(hold_bad), 64'd0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (done8) extra++; end
    chk("b2b no_extra", 64'(extra), 64'd0);
    chk("b2b mult_hold", 64'(mult8), 64'h0090);

    // Reset two edges after accept discards the operation.
    sm8 = 1'b0; a8 = 8'h7F; b8 = 8'h7F; valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst ready", 64'(ready8), 64'd1);
    chk("rst done", 64'(done8), 64'd0);
    chk("rst mult", 64'(mult8), 64'd0);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (done8) extra++; end
    chk("rst no_done", 64'(extra), 64'd0);
    chk("rst mult_stays0", 64'(mult8), 64'd0);
    op8("post_rst s05x06", 1'b1, 8'h05, 8'h06, 16'h001E, 1'b1);

    op16("n16 s8000x8000", 1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1);
    op16("n16 uFFFFxFFFF", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    op16("n16 sFFFFx0002", 1'b1, 16'hFFFF, 16'h0002, 32'hFFFFFFFE, 1'b1);

    for (int i = 0; i < 1200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      x = rs ? longint'($signed(ra)) : longint'(ra);
      y = rs ? longint'($signed(rb)) : longint'(rb);
      op8("rand8", rs, ra, rb, 16'(x * y), 1'b0);
    end
    for (int i = 0; i < 1200; i++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom); rs = 1'($urandom);
      x = rs ? longint'($signed(ra16)) : longint'(ra16);
      y = rs ? longint'($signed(rb16)) : longint'(rb16);
      op16("rand16", rs, ra16, rb16, 32'(x * y), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
